fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning datapath and address width in bits.
REQ-002 The module SHALL have parameter IMEM_WORDS, default 1024, meaning instruction memory depth in words (power of two).
REQ-003 The module SHALL have parameter FQ_DEPTH, default 4, meaning fetch queue entries (power of two, >=2).
REQ-004 The module SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-005 The module SHALL have parameter NOP_INSTR, default 32'h00000013, meaning instruction returned for out-of-range fetches.
REQ-006 Ports: clk  in  1  clock; all state changes on its rising edge.
REQ-007 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-008 Ports: redirect_valid  in  1  branch/jump taken; flush and load new PC.
REQ-009 Ports: redirect_pc  in  XLEN  redirect target address.
REQ-010 Ports: imem_we  in  1  instruction memory load write enable.
REQ-011 Ports: imem_waddr  in  XLEN  byte address of the load write.
REQ-012 Ports: imem_wdata  in  XLEN  load write data.
REQ-013 Ports: if_id_ready  in  1  decode accepts the head entry this cycle.
REQ-014 Ports: if_id_valid  out  1  head entry valid.
REQ-015 Ports: if_id_instr  out  XLEN  head instruction.
REQ-016 Ports: if_id_pc  out  XLEN  head instruction address.
REQ-017 Ports: if_id_npc  out  XLEN  head instruction address + 4.
REQ-018 Ports: fq_count  out  clog2(FQ_DEPTH)+1  queue occupancy.

Function
REQ-019 Memory: IMEM_WORDS x XLEN array; combinational read indexed by pc[clog2(IMEM_WORDS)+1:2]; address bits [1:0] SHALL be ignored.
REQ-020 Fetch address >= 4*IMEM_WORDS SHALL return NOP_INSTR.
REQ-021 imem_we SHALL write imem_wdata at word imem_waddr[..:2] on the edge; out-of-range writes are dropped; a fetch of the same word in the same cycle returns the old data.
REQ-022 Push condition: !redirect_valid && (fq_count < FQ_DEPTH || pop); push enqueues {pc, pc+4, mem[pc]} and pc <= pc+4 (mod 2^XLEN).
REQ-023 No push: pc SHALL hold.
REQ-024 Pop condition: if_id_valid && if_id_ready; the head is removed on the edge.
REQ-025 Simultaneous push and pop SHALL leave fq_count unchanged, including when the queue is full.
REQ-026 Outputs SHALL reflect the queue head combinationally from registers; if_id_valid = (fq_count != 0).
REQ-027 While !if_id_valid, if_id_instr/pc/npc SHALL be 0.
REQ-028 Redirect SHALL have priority over push and pop: queue flushed (fq_count <= 0), pc <= {redirect_pc[XLEN-1:2],2'b00}, no push; a pop in the same cycle is discarded.
REQ-029 Latency: an instruction at address A SHALL be visible on if_id_* one edge after the fetch of A; the first valid output appears one edge after redirect or reset release.
REQ-030 Read/write pointers SHALL wrap modulo FQ_DEPTH; fq_count SHALL never exceed FQ_DEPTH nor underflow.

Reset
REQ-031 When rst is asserted: pc = RESET_PC, queue pointers = 0, fq_count = 0, and if_id_valid = 0, immediately and independent of clk.
REQ-032 Memory contents SHALL NOT be altered by reset.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries; fetch resumes at RESET_PC after release.

Verification
REQ-034 Load mem[0..3] = 11,22,33,44; release reset; if_id_ready=1 -> instr 11,22,33,44 on consecutive cycles, pc 0,4,8,C, npc 4,8,C,10.
REQ-035 if_id_ready=0 for 6 cycles -> fq_count saturates at 4, pc holds at 0x10, head stays instr 11/pc 0; ready=1 -> in-order drain without loss or duplication.
REQ-036 Full queue, ready=1 -> fq_count stays 4 every cycle (simultaneous push/pop).
REQ-037 redirect_valid=1 with redirect_pc=0x0000000A while 3 entries are queued -> next cycle if_id_valid=0 and fq_count=0; following cycle pc 0x8 and instr mem[2].
REQ-038 Redirect to 4*IMEM_WORDS -> if_id_instr = NOP_INSTR, pc = 0x1000.
REQ-039 rst asserted mid-stream with queue full -> if_id_valid=0 asynchronously; after release first pc = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, load-writable instruction memory and a
// fetch queue feeding decode through a valid/ready head interface.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_WORDS = 1024,
    parameter int              FQ_DEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h00000013)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        imem_we,
    input  logic [XLEN-1:0]             imem_waddr,
    input  logic [XLEN-1:0]             imem_wdata,
    input  logic                        if_id_ready,
    output logic                        if_id_valid,
    output logic [XLEN-1:0]             if_id_instr,
    output logic [XLEN-1:0]             if_id_pc,
    output logic [XLEN-1:0]             if_id_npc,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    localparam int AW = $clog2(IMEM_WORDS);
    localparam int QW = $clog2(FQ_DEPTH);
    localparam int CW = QW + 1;

    logic [XLEN-1:0] r_mem [IMEM_WORDS];

    logic [XLEN-1:0] r_q_instr [FQ_DEPTH];
    logic [XLEN-1:0] r_q_pc    [FQ_DEPTH];
    logic [XLEN-1:0] r_q_npc   [FQ_DEPTH];

    logic [XLEN-1:0] r_pc;
    logic [QW-1:0]   r_wptr;
    logic [QW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_fetch_ok;
    logic            w_wr_ok;
    logic [XLEN-1:0] w_fetch_instr;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_unused;

    // Anything at or beyond the end of the array is out of range.
    assign w_fetch_ok = (r_pc[XLEN-1:AW+2] == '0);
    assign w_wr_ok    = (imem_waddr[XLEN-1:AW+2] == '0);

    assign w_fetch_instr = w_fetch_ok ? r_mem[r_pc[AW+1:2]] : NOP_INSTR;
    assign w_pc_plus4    = r_pc + XLEN'(4);

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && if_id_ready;
    assign w_push  = !redirect_valid &&
                     ((r_count < CW'(FQ_DEPTH)) || w_pop);

    // Byte-offset bits are ignored for both write and redirect addresses.
    assign w_unused = ^{imem_waddr[1:0], redirect_pc[1:0]};

    // Load port; memory is never touched by reset.
    always_ff @(posedge clk) begin
        if (imem_we && w_wr_ok) begin
            r_mem[imem_waddr[AW+1:2]] <= imem_wdata;
        end
    end

    // Queue payload storage; the head is masked by valid on output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wptr] <= w_fetch_instr;
            r_q_pc[r_wptr]    <= r_pc;
            r_q_npc[r_wptr]   <= w_pc_plus4;
        end
    end

    // PC, pointers and occupancy; redirect flushes and wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= w_pc_plus4;
                r_wptr <= r_wptr + QW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + QW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign if_id_valid = w_valid;
    assign if_id_instr = w_valid ? r_q_instr[r_rptr] : '0;
    assign if_id_pc    = w_valid ? r_q_pc[r_rptr]    : '0;
    assign if_id_npc   = w_valid ? r_q_npc[r_rptr]   : '0;
    assign fq_count    = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected
// decode-side transfers, a negedge monitor pops and compares them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_we = 1'b0;
    logic [31:0] imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        if_id_ready = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_npc;
    logic [2:0]  fq_count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .if_id_ready    (if_id_ready),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_npc      (if_id_npc),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_item(logic [31:0] i, logic [31:0] p);
        exp_q.push_back('{instr: i, pc: p, npc: p + 32'd4});
    endtask

    task automatic redirect(logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Monitor: every accepted head must match the next expected entry.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && if_id_valid && if_id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h expected none",
                         if_id_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", if_id_instr, e.instr);
                chk("sb_pc", if_id_pc, e.pc);
                chk("sb_npc", if_id_npc, e.npc);
            end
        end
    end

    initial begin
        #2;
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_count", 32'(fq_count), 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_npc", if_id_npc, 32'd0);

        for (int i = 0; i < 32; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 32'(i * 4);
            imem_wdata = 32'h11 * 32'(i + 1);
            tick();
        end
        imem_waddr = 32'h1000;
        imem_wdata = 32'hDEADBEEF;
        tick();
        imem_we = 1'b0;
        chk("rst_hold_valid", 32'(if_id_valid), 32'd0);

        rst         = 1'b0;
        if_id_ready = 1'b1;
        expect_item(32'h11, 32'h0);
        expect_item(32'h22, 32'h4);
        expect_item(32'h33, 32'h8);
        expect_item(32'h44, 32'hC);
        tick();
        chk("first_valid", 32'(if_id_valid), 32'd1);
        chk("first_pc", if_id_pc, 32'h0);
        chk("first_count", 32'(fq_count), 32'd1);
        repeat (4) tick();
        if_id_ready = 1'b0;

        redirect(32'h0);
        chk("flush_valid", 32'(if_id_valid), 32'd0);
        chk("flush_count", 32'(fq_count), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("fill_count", 32'(fq_count), (i < 4) ? 32'(i) : 32'd4);
        end
        chk("stall_instr", if_id_instr, 32'h11);
        chk("stall_pc", if_id_pc, 32'h0);
        chk("stall_npc", if_id_npc, 32'h4);

        for (int i = 0; i < 8; i++) begin
            expect_item(32'h11 * 32'(i + 1), 32'(i * 4));
        end
        if_id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("full_pp_count", 32'(fq_count), 32'd4);
        end
        if_id_ready = 1'b0;
        chk("after_drain_pc", if_id_pc, 32'h20);
        chk("after_drain_instr", if_id_instr, 32'h99);

        redirect(32'h0);
        repeat (3) tick();
        chk("three_queued", 32'(fq_count), 32'd3);
        redirect(32'hA);
        chk("redir_valid", 32'(if_id_valid), 32'd0);
        chk("redir_count", 32'(fq_count), 32'd0);
        chk("redir_instr", if_id_instr, 32'd0);
        tick();
        chk("redir_new_valid", 32'(if_id_valid), 32'd1);
        chk("redir_new_pc", if_id_pc, 32'h8);
        chk("redir_new_instr", if_id_instr, 32'h33);
        chk("redir_new_npc", if_id_npc, 32'hC);

        redirect(32'h1000);
        tick();
        chk("oor_instr", if_id_instr, 32'h13);
        chk("oor_pc", if_id_pc, 32'h1000);
        chk("oor_npc", if_id_npc, 32'h1004);
        expect_item(32'h13, 32'h1000);
        if_id_ready = 1'b1;
        tick();
        if_id_ready = 1'b0;
        chk("oor_next_count", 32'(fq_count), 32'd1);
        chk("oor_next_pc", if_id_pc, 32'h1004);
        chk("oor_next_instr", if_id_instr, 32'h13);

        redirect(32'h40);
        imem_we    = 1'b1;
        imem_waddr = 32'h40;
        imem_wdata = 32'hCAFEF00D;
        tick();
        imem_we = 1'b0;
        chk("wr_same_pc", if_id_pc, 32'h40);
        chk("wr_same_old", if_id_instr, 32'h121);
        redirect(32'h40);
        tick();
        chk("wr_new_data", if_id_instr, 32'hCAFEF00D);

        repeat (3) tick();
        chk("pre_rst_full", 32'(fq_count), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(if_id_valid), 32'd0);
        chk("async_rst_count", 32'(fq_count), 32'd0);
        chk("async_rst_instr", if_id_instr, 32'd0);

        tick();
        chk("rst_edge_valid", 32'(if_id_valid), 32'd0);
        rst         = 1'b0;
        if_id_ready = 1'b1;
        expect_item(32'h11, 32'h0);
        expect_item(32'h22, 32'h4);
        tick();
        chk("rerun_pc", if_id_pc, 32'h0);
        repeat (2) tick();
        if_id_ready = 1'b0;
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
